rv_instr_encoder: RTL
=====================

// Module: rv_instr_encoder
// PURPOSE
//  Inverse of the instruction decoder: packs RV32I instruction fields into a 32-bit word.
//  Feeds the instruction-memory loader and self-checking benches.
//  Provides a one-deep registered output stage with a valid/ready handshake on both sides.
//  Checks immediate ranges and field legality, and tags each word with an auto-incrementing byte address.
// PARAMETERS
//  ADDR_W     32            width of out_addr
//  BASE_ADDR  32'h0000_0000 address loaded at reset and on start
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   synchronous; reloads out_addr to BASE_ADDR, clears err_sticky
//  in_valid   in   1   input fields valid
//  in_ready   out  1   encoder accepts this cycle
//  in_class   in   4   0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 AUIPC, 8 LUI; 9-15 illegal
//  in_funct3  in   3   funct3 field
//  in_alt     in   1   funct7[5] (SUB/SRA/SRAI)
//  in_rd      in   5   destination register
//  in_rs1     in   5   source register 1
//  in_rs2     in   5   source register 2
//  in_imm     in   32  byte-offset or value immediate, two's complement
//  out_valid  out  1   out_instr and out_addr valid
//  out_ready  in   1   sink accepts
//  out_instr  out  32  encoded instruction
//  out_addr   out  ADDR_W  byte address of out_instr
//  err_pulse  out  1   one cycle high per rejected input
//  err_sticky out  1   set by any rejection; cleared by rst or start
// BEHAVIOUR
//  Reset: out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_pulse=0, err_sticky=0.
//  Handshake:
//   - in_ready = !out_valid || out_ready (combinational).
//   - An input is accepted when in_valid && in_ready; the word is registered with 1-cycle latency.
//   - out_valid holds, and out_instr/out_addr stay stable, until out_ready.
//   - Accept and drain in the same cycle: the new word replaces the old one, with no bubble.
//  Address: out_addr += 4 after each word drains (out_valid && out_ready); wraps modulo 2^ADDR_W.
//  start: has priority over an increment in the same cycle.
//  start with out_valid=1: the held word keeps its address; the next drained word carries BASE_ADDR.
//  Fields are placed at the same bit positions the decoder extracts.
//  Immediate rules (any violation rejects the input):
//   - I/LOAD/JALR/STORE: imm must be in -2048..2047.
//   - I shifts (funct3 001/101): imm[31:5]=0; SRAI sets instr[30].
//   - BRANCH: imm even and in -4096..4094.
//   - JAL: imm even and in +-1 MiB.
//   - AUIPC/LUI: imm[11:0]=0; instr[31:12]=imm[31:12].
//  Legality (any violation rejects the input):
//   - R: in_alt only with funct3 000/101.
//   - I: in_alt only with funct3 101.
//   - LOAD funct3 in {000,001,010,100,101}; STORE funct3 in {000,001,010}.
//   - BRANCH funct3 not 010/011; JALR funct3=000; classes 9-15 illegal.
//   - Fields unused by the class are ignored.
//  Rejection: err_pulse is high in the cycle after acceptance and err_sticky sets.
//  A rejected input still consumes one handshake.
//  Reset mid-transfer discards any held word.
// CONFIGURATION
//  RV_ENC_ILLEGAL_AS_NOP_EN
//   - defined: a rejected input emits NOP 32'h0000_0013 and consumes an address; keeps the program image aligned.
//   - undefined: a rejected input emits nothing (out_valid stays 0 for it) and does not advance out_addr.
//   - err_pulse and err_sticky behave the same in both builds.
// TESTING
//  1 R ADD rd=3 rs1=1 rs2=2 -> out_instr=32'h002081B3, out_addr=BASE_ADDR, latency 1 cycle.
//  2 I ADDI rd=1 rs1=0 imm=-1 -> 32'hFFF00093; then BRANCH f3=000 rs1=1 rs2=2 imm=8 -> 32'h00208463 at addr+4.
//  3 LUI rd=5 imm=32'h12345000 -> 32'h123452B7; LUI with imm=32'h12345001 -> err_pulse and err_sticky.
//  4 ADDI imm=2048 -> rejected; with the macro: 32'h00000013 and addr advances; without: no output, addr unchanged.
//  5 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_instr stable, no input lost; pattern of 8 words in order.
//  6 rst asserted while out_valid=1 -> out_valid=0 and out_addr=BASE_ADDR immediately; start pulse -> next word at BASE_ADDR.

Source files
------------

// File: rtl/rv_instr_encoder_if.sv
// Bus for rv_instr_encoder: input field channel, output word channel,
// start control and error flags. The master drives fields and out_ready;
// the slave (the encoder) drives in_ready, the output word and error flags.
interface rv_instr_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_class;
  logic [2:0]        in_funct3;
  logic              in_alt;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err_pulse;
  logic              err_sticky;

  modport master (
    output start, in_valid, in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2,
           in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err_pulse, err_sticky
  );

  modport slave (
    input  start, in_valid, in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2,
           in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err_pulse, err_sticky
  );
endinterface

// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: packs RV32I fields into a 32-bit instruction word behind a
// one-deep registered output stage, checks immediate ranges / field legality,
// and tags each word with an auto-incrementing byte address.
// Optional feature macro: RV_ENC_ILLEGAL_AS_NOP_EN -- when defined, a rejected
// input emits a NOP (32'h0000_0013) that consumes an address slot.
//
// Handshake (both channels): a transfer happens on a rising edge where
// valid && ready are both high; valid never depends on ready, and a raised
// out_valid holds with stable out_instr/out_addr until out_ready is seen.
module rv_instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic             clk,
  input logic             rst,
  rv_instr_encoder_if.slave bus
);
  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_I      = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              base_pend_q, base_pend_d;  // next drained word restarts at BASE_ADDR
  logic              err_pulse_q, err_pulse_d;
  logic              err_sticky_q, err_sticky_d;

  logic        accept, drain, emit;
  logic [31:0] enc;
  logic        legal;
  logic [31:0] imm;
  logic [2:0]  f3;
  logic        imm12_ok, imm13_ok, imm21_ok, shamt_ok;

  assign imm = bus.in_imm;
  assign f3  = bus.in_funct3;

  // Signed-range checks: the bits above the field must all equal the sign bit.
  assign imm12_ok = (imm[31:11] == {21{imm[31]}});
  assign imm13_ok = (imm[31:12] == {20{imm[31]}}) && !imm[0];
  assign imm21_ok = (imm[31:20] == {12{imm[31]}}) && !imm[0];
  assign shamt_ok = (imm[31:5] == 27'd0);

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = out_valid_q && bus.out_ready;

  // Field packing and legality check for the presented input.
  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (bus.in_class)
      4'd0: begin
        enc   = {1'b0, bus.in_alt, 5'd0, bus.in_rs2, bus.in_rs1, f3, bus.in_rd, OP_R};
        legal = !bus.in_alt || (f3 == 3'b000) || (f3 == 3'b101);
      end
      4'd1: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          enc   = {1'b0, bus.in_alt, 5'd0, imm[4:0], bus.in_rs1, f3, bus.in_rd, OP_I};
          legal = shamt_ok && (!bus.in_alt || f3 == 3'b101);
        end else begin
          enc   = {imm[11:0], bus.in_rs1, f3, bus.in_rd, OP_I};
          legal = imm12_ok && !bus.in_alt;
        end
      end
      4'd2: begin
        enc   = {imm[11:0], bus.in_rs1, f3, bus.in_rd, OP_LOAD};
        legal = imm12_ok && (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      4'd3: begin
        enc   = {imm[11:5], bus.in_rs2, bus.in_rs1, f3, imm[4:0], OP_STORE};
        legal = imm12_ok && (f3 <= 3'b010);
      end
      4'd4: begin
        enc   = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, f3, imm[4:1], imm[11], OP_BRANCH};
        legal = imm13_ok && (f3 != 3'b010) && (f3 != 3'b011);
      end
      4'd5: begin
        enc   = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, OP_JAL};
        legal = imm21_ok;
      end
      4'd6: begin
        enc   = {imm[11:0], bus.in_rs1, f3, bus.in_rd, OP_JALR};
        legal = imm12_ok && (f3 == 3'b000);
      end
      4'd7: begin
        enc   = {imm[31:12], bus.in_rd, OP_AUIPC};
        legal = (imm[11:0] == 12'd0);
      end
      4'd8: begin
        enc   = {imm[31:12], bus.in_rd, OP_LUI};
        legal = (imm[11:0] == 12'd0);
      end
      default: begin
        enc   = '0;
        legal = 1'b0;
      end
    endcase
  end

  // Output stage next state: a new word replaces the held one without a bubble.
  always_comb begin
`ifdef RV_ENC_ILLEGAL_AS_NOP_EN
    emit        = accept;
    out_instr_d = out_instr_q;
    if (accept) out_instr_d = legal ? enc : NOP_INSTR;
`else
    emit        = accept && legal;
    out_instr_d = out_instr_q;
    if (emit) out_instr_d = enc;
`endif
    if (emit)       out_valid_d = 1'b1;
    else if (drain) out_valid_d = 1'b0;
    else            out_valid_d = out_valid_q;
    err_pulse_d  = accept && !legal;
    err_sticky_d = err_pulse_d || (err_sticky_q && !bus.start);
  end

  // Address next state: start beats increment; a held word keeps its address.
  always_comb begin
    addr_d      = addr_q;
    base_pend_d = base_pend_q;
    if (bus.start) begin
      if (out_valid_q && !drain) begin
        base_pend_d = 1'b1;
      end else begin
        addr_d      = BASE_ADDR;
        base_pend_d = 1'b0;
      end
    end else if (drain) begin
      addr_d      = base_pend_q ? BASE_ADDR : addr_q + ADDR_W'(4);
      base_pend_d = 1'b0;
    end
  end

  // State registers; reset discards any held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      addr_q       <= BASE_ADDR;
      base_pend_q  <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      addr_q       <= addr_d;
      base_pend_q  <= base_pend_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_instr  = out_instr_q;
  assign bus.out_addr   = addr_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_sticky = err_sticky_q;
endmodule
